multicycle_alu: RTL

Parametrised, handshaked successor to the combinational datapath ALU. It adds registered outputs, valid/ready flow control and iterative unsigned multiply, divide and remainder. It sits between the instruction decoder/issue stage and writeback: one operation is accepted per handshake and one result is returned per handshake. Simple ops take 1 cycle; MUL/DIV/REM take WIDTH cycles.

---
 rtl/multicycle_alu.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_alu
// Description : Handshaked ALU with registered result and flags. Simple ops
//               complete in one cycle; MULU (shift-add) and DIVU/REMU
//               (restoring division) iterate one bit per cycle for WIDTH
//               cycles on a shared 2*WIDTH accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             negative_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_AND  = 4'b0010;
    localparam logic [3:0] c_OP_OR   = 4'b0011;
    localparam logic [3:0] c_OP_XOR  = 4'b0100;
    localparam logic [3:0] c_OP_NOR  = 4'b0101;
    localparam logic [3:0] c_OP_SLT  = 4'b0110;
    localparam logic [3:0] c_OP_SLTU = 4'b0111;
    localparam logic [3:0] c_OP_SLL  = 4'b1000;
    localparam logic [3:0] c_OP_SRL  = 4'b1001;
    localparam logic [3:0] c_OP_SRA  = 4'b1010;
    localparam logic [3:0] c_OP_MULU = 4'b1011;
    localparam logic [3:0] c_OP_DIVU = 4'b1100;
    localparam logic [3:0] c_OP_REMU = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;

    logic               w_accept;
    logic               w_is_multi;

    // single-cycle datapath
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_sc_res;
    logic               w_sc_carry;
    logic               w_sc_ovf;

    // iterative datapath
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_trial;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_acc_next;

    // result register load
    logic               w_load;
    logic [WIDTH-1:0]   w_res_d;
    logic               w_carry_d;
    logic               w_ovf_d;
    logic               w_dbz_d;

    assign in_ready   = (r_state == S_IDLE) || (r_state == S_DONE && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_is_multi = (ALU_control == c_OP_MULU) || (ALU_control == c_OP_DIVU) ||
                        (ALU_control == c_OP_REMU);
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state == S_BUSY);

    // Single-cycle operations evaluated straight from the live operands
    always_comb begin
        w_sum      = {1'b0, operandA} + {1'b0, operandB};
        w_diff     = {1'b0, operandA} - {1'b0, operandB};
        w_sh       = operandB[SHW-1:0];
        w_sc_res   = '0;
        w_sc_carry = 1'b0;
        w_sc_ovf   = 1'b0;
        case (ALU_control)
            c_OP_ADD: begin
                w_sc_res   = w_sum[WIDTH-1:0];
                w_sc_carry = w_sum[WIDTH];
                w_sc_ovf   = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != operandA[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_sc_res   = w_diff[WIDTH-1:0];
                w_sc_carry = w_diff[WIDTH];
                w_sc_ovf   = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != operandA[WIDTH-1]);
            end
            c_OP_AND:  w_sc_res = operandA & operandB;
            c_OP_OR:   w_sc_res = operandA | operandB;
            c_OP_XOR:  w_sc_res = operandA ^ operandB;
            c_OP_NOR:  w_sc_res = ~(operandA | operandB);
            c_OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
            c_OP_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, (operandA < operandB)};
            c_OP_SLL:  w_sc_res = operandA << w_sh;
            c_OP_SRL:  w_sc_res = operandA >> w_sh;
            c_OP_SRA:  w_sc_res = $unsigned($signed(operandA) >>> w_sh);
            default:   w_sc_res = '0;
        endcase
    end

    // One shift-add or restoring-division step on the accumulator
    always_comb begin
        // multiply: {hi, lo} with the multiplier in lo, product shifts in from the top
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_a : {WIDTH{1'b0}})};
        w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};
        // divide: remainder in hi, dividend/quotient in lo, shifted left one bit
        w_div_trial = r_acc[2*WIDTH-1:WIDTH-1];
        w_div_ge    = (w_div_trial >= {1'b0, r_b});
        w_div_rem   = w_div_trial[WIDTH-1:0] - r_b;
        w_div_next  = {(w_div_ge ? w_div_rem : w_div_trial[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_div_ge};
        w_acc_next  = (r_op == c_OP_MULU) ? w_mul_next : w_div_next;
    end

    // Select what gets written into the result/flag registers and when
    always_comb begin
        w_load    = 1'b0;
        w_res_d   = w_sc_res;
        w_carry_d = w_sc_carry;
        w_ovf_d   = w_sc_ovf;
        w_dbz_d   = 1'b0;
        if (r_state == S_BUSY) begin
            w_load    = (r_cnt == '0);
            w_carry_d = 1'b0;
            w_ovf_d   = 1'b0;
            case (r_op)
                c_OP_MULU: begin
                    w_res_d   = w_mul_next[WIDTH-1:0];
                    w_carry_d = |w_mul_next[2*WIDTH-1:WIDTH];
                end
                c_OP_DIVU: begin
                    w_res_d = w_div_next[WIDTH-1:0];
                    w_dbz_d = (r_b == '0);
                end
                c_OP_REMU: begin
                    w_res_d = w_div_next[2*WIDTH-1:WIDTH];
                    w_dbz_d = (r_b == '0);
                end
                default: w_res_d = '0;
            endcase
        end else if (w_accept && !w_is_multi) begin
            w_load = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_is_multi ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_state_next = w_is_multi ? S_BUSY : S_DONE;
                end else if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand capture, iteration and result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_acc         <= '0;
            r_cnt         <= '0;
            result        <= '0;
            zero_flag     <= 1'b0;
            negative_flag <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            div_by_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= ALU_control;
                r_a   <= operandA;
                r_b   <= operandB;
                r_cnt <= CW'(WIDTH - 1);
                r_acc <= (ALU_control == c_OP_MULU) ? {{WIDTH{1'b0}}, operandB}
                                                    : {{WIDTH{1'b0}}, operandA};
            end else if (r_state == S_BUSY) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_load) begin
                result        <= w_res_d;
                zero_flag     <= (w_res_d == '0);
                negative_flag <= w_res_d[WIDTH-1];
                carry_flag    <= w_carry_d;
                overflow_flag <= w_ovf_d;
                div_by_zero   <= w_dbz_d;
            end
        end
    end

endmodule
`default_nettype wire
